// File: rtl/aes_inv_cipher_top.sv
// AES-128 inverse cipher: pre-expands the key into an 11-entry round-key store,
// then decrypts one round per clock (load, initial AddRoundKey, 9 full rounds, final round).
module aes_inv_cipher_top (
    input  logic         clk,
    input  logic         rst,
    input  logic         kld,
    input  logic [127:0] key,
    output logic         key_rdy,
    input  logic         ld,
    input  logic [127:0] text_in,
    output logic         done,
    output logic [127:0] text_out
);
    localparam int unsigned BLK_W = 128;
    localparam int unsigned NR    = 10;
    localparam int unsigned RND_W = 4;

    typedef enum logic [1:0] {S_IDLE, S_KEXP, S_READY, S_DEC} fsm_e;

    // Element 255 (MSB) holds the entry for input 8'h00.
    localparam logic [255:0][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [255:0][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox_f(input logic [7:0] b);
        return SBOX[8'hff - b];
    endfunction

    function automatic logic [7:0] inv_sbox_f(input logic [7:0] b);
        return INV_SBOX[8'hff - b];
    endfunction

    function automatic logic [7:0] xtime_f(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by one of the InvMixColumns coefficients 09/0b/0d/0e.
    function automatic logic [7:0] gm_f(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] x2, x4, x8, r;
        x2 = xtime_f(b);
        x4 = xtime_f(x2);
        x8 = xtime_f(x4);
        case (k)
            4'h9:    r = x8 ^ b;
            4'hb:    r = x8 ^ x2 ^ b;
            4'hd:    r = x8 ^ x4 ^ b;
            default: r = x8 ^ x4 ^ x2;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] inv_mix_col_f(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {gm_f(a0, 4'he) ^ gm_f(a1, 4'hb) ^ gm_f(a2, 4'hd) ^ gm_f(a3, 4'h9),
                gm_f(a0, 4'h9) ^ gm_f(a1, 4'he) ^ gm_f(a2, 4'hb) ^ gm_f(a3, 4'hd),
                gm_f(a0, 4'hd) ^ gm_f(a1, 4'h9) ^ gm_f(a2, 4'he) ^ gm_f(a3, 4'hb),
                gm_f(a0, 4'hb) ^ gm_f(a1, 4'hd) ^ gm_f(a2, 4'h9) ^ gm_f(a3, 4'he)};
    endfunction

    function automatic logic [127:0] inv_mix_columns_f(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127 - 32*c -: 32] = inv_mix_col_f(s[127 - 32*c -: 32]);
        end
        return o;
    endfunction

    // Byte 4c+r sits at row r, column c; row r rotates right by r.
    function automatic logic [127:0] inv_shift_sub_f(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = inv_sbox_f(s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon_f(input logic [RND_W-1:0] i);
        logic [7:0] r;
        case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [127:0] key_next_f(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox_f(k[23:16]), sbox_f(k[15:8]), sbox_f(k[7:0]), sbox_f(k[31:24])} ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    fsm_e              fsm_q, fsm_d;
    logic [RND_W-1:0]  rnd_q, rnd_d;
    logic [BLK_W-1:0]  blk_q, blk_d;
    logic [BLK_W-1:0]  text_out_q, text_out_d;
    logic              done_q, done_d;
    logic              key_rdy_q, key_rdy_d;
    logic [BLK_W-1:0]  rk_q [NR+1];
    logic [BLK_W-1:0]  rk_d [NR+1];

    logic [BLK_W-1:0]  rk_cur, rk_prev, rk_next, isb, round_out;

    // Round-key selection for the current round / previous key for expansion.
    always_comb begin
        rk_cur  = '0;
        rk_prev = '0;
        for (int unsigned i = 0; i <= NR; i++) begin
            if (rnd_q == RND_W'(i)) rk_cur = rk_q[i];
        end
        for (int unsigned i = 1; i <= NR; i++) begin
            if (rnd_q == RND_W'(i)) rk_prev = rk_q[i-1];
        end
    end

    always_comb begin
        rk_next   = key_next_f(rk_prev, rcon_f(rnd_q));
        isb       = inv_shift_sub_f(blk_q);
        round_out = inv_mix_columns_f(isb ^ rk_cur);
    end

    always_comb begin
        fsm_d      = fsm_q;
        rnd_d      = rnd_q;
        blk_d      = blk_q;
        text_out_d = text_out_q;
        done_d     = 1'b0;
        key_rdy_d  = key_rdy_q;
        rk_d       = rk_q;

        // A key load outside DEC always wins and restarts expansion.
        if (kld && (fsm_q != S_DEC)) begin
            fsm_d     = S_KEXP;
            rk_d[0]   = key;
            rnd_d     = RND_W'(1);
            key_rdy_d = 1'b0;
        end else begin
            case (fsm_q)
                S_KEXP: begin
                    for (int unsigned i = 1; i <= NR; i++) begin
                        if (rnd_q == RND_W'(i)) rk_d[i] = rk_next;
                    end
                    if (rnd_q == RND_W'(NR)) begin
                        fsm_d     = S_READY;
                        rnd_d     = '0;
                        key_rdy_d = 1'b1;
                    end else begin
                        rnd_d = rnd_q + RND_W'(1);
                    end
                end
                S_READY: begin
                    if (ld) begin
                        blk_d = text_in;
                        rnd_d = RND_W'(NR);
                        fsm_d = S_DEC;
                    end
                end
                S_DEC: begin
                    if (rnd_q == RND_W'(NR)) begin
                        blk_d = blk_q ^ rk_cur;
                        rnd_d = rnd_q - RND_W'(1);
                    end else if (rnd_q != '0) begin
                        blk_d = round_out;
                        rnd_d = rnd_q - RND_W'(1);
                    end else begin
                        text_out_d = isb ^ rk_cur;
                        done_d     = 1'b1;
                        // The final-round cycle can accept the next block back to back.
                        if (ld && !kld) begin
                            blk_d = text_in;
                            rnd_d = RND_W'(NR);
                        end else begin
                            fsm_d = S_READY;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q      <= S_IDLE;
            rnd_q      <= '0;
            blk_q      <= '0;
            text_out_q <= '0;
            done_q     <= 1'b0;
            key_rdy_q  <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            rnd_q      <= rnd_d;
            blk_q      <= blk_d;
            text_out_q <= text_out_d;
            done_q     <= done_d;
            key_rdy_q  <= key_rdy_d;
        end
    end

    // Round-key store needs no reset; it is only read after a completed expansion.
    always_ff @(posedge clk) begin
        rk_q <= rk_d;
    end

    assign key_rdy  = key_rdy_q;
    assign done     = done_q;
    assign text_out = text_out_q;

endmodule

// File: tb/tb_aes_inv_cipher_top.sv
// Directed bench for aes_inv_cipher_top: FIPS-197 vectors, back-to-back blocks,
// round trip against a forward-cipher model, ignored strobes and reset mid-operation.
module tb_aes_inv_cipher_top;
    logic         clk = 1'b0;
    logic         rst, kld, ld;
    logic [127:0] key, text_in;
    logic         key_rdy, done;
    logic [127:0] text_out;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_E2  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] PT_E2  = 128'h6bc1bee22e409f96e93d7e117393172a;

    aes_inv_cipher_top dut (
        .clk(clk), .rst(rst), .kld(kld), .key(key), .key_rdy(key_rdy),
        .ld(ld), .text_in(text_in), .done(done), .text_out(text_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Forward-cipher reference model (S-box from GF inversion + affine map).
    function automatic logic [7:0] gmul_f(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] ref_sbox_f(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h01;
        if (a == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul_f(inv, a);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] ref_encrypt_f(input logic [127:0] pt, input logic [127:0] k);
        logic [127:0] rk, s, t;
        logic [31:0]  w;
        logic [7:0]   rc, a0, a1, a2, a3;
        rk = k;
        rc = 8'h01;
        s  = pt ^ rk;
        for (int rnd = 1; rnd <= 10; rnd++) begin
            w = {ref_sbox_f(rk[23:16]), ref_sbox_f(rk[15:8]), ref_sbox_f(rk[7:0]),
                 ref_sbox_f(rk[31:24])} ^ {rc, 24'h0};
            rk[127:96] = rk[127:96] ^ w;
            rk[95:64]  = rk[95:64] ^ rk[127:96];
            rk[63:32]  = rk[63:32] ^ rk[95:64];
            rk[31:0]   = rk[31:0] ^ rk[63:32];
            rc = gmul_f(rc, 8'h02);
            t = '0;
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[127 - 8*(4*c + r) -: 8] = ref_sbox_f(s[127 - 8*(4*((c + r) % 4) + r) -: 8]);
            if (rnd != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[127 - 32*c -: 8];
                    a1 = t[119 - 32*c -: 8];
                    a2 = t[111 - 32*c -: 8];
                    a3 = t[103 - 32*c -: 8];
                    t[127 - 32*c -: 8] = gmul_f(a0, 8'h02) ^ gmul_f(a1, 8'h03) ^ a2 ^ a3;
                    t[119 - 32*c -: 8] = a0 ^ gmul_f(a1, 8'h02) ^ gmul_f(a2, 8'h03) ^ a3;
                    t[111 - 32*c -: 8] = a0 ^ a1 ^ gmul_f(a2, 8'h02) ^ gmul_f(a3, 8'h03);
                    t[103 - 32*c -: 8] = gmul_f(a0, 8'h03) ^ a1 ^ a2 ^ gmul_f(a3, 8'h02);
                end
            end
            s = t ^ rk;
        end
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [127:0] k);
        kld = 1'b1;
        key = k;
        step();
        kld = 1'b0;
    endtask

    task automatic send_blk(input logic [127:0] ct);
        ld      = 1'b1;
        text_in = ct;
        step();
        ld = 1'b0;
    endtask

    // Edges until key_rdy is seen high; 0 if it never rises within the budget.
    task automatic wait_key(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (key_rdy === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    // Edges until done is seen high; 0 if no done within the budget.
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (done === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        checks++; if (key_rdy !== 1'b0) begin errors++; $display("FAIL reset_key_rdy: got %b want 0", key_rdy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (text_out !== 128'h0) begin errors++; $display("FAIL reset_text_out: got %h want 0", text_out); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_fips_c1();
        int c;
        load_key(KEY_C1);
        checks++; if (key_rdy !== 1'b0) begin errors++; $display("FAIL c1_key_rdy_low: got %b want 0", key_rdy); end
        wait_key(c);
        checks++; if (c != 10) begin errors++; $display("FAIL c1_key_latency: got %0d want 10", c); end
        send_blk(CT_C1);
        wait_done(c);
        checks++; if (c != 11) begin errors++; $display("FAIL c1_done_latency: got %0d want 11", c); end
        checks++; if (text_out !== PT_C1) begin errors++; $display("FAIL c1_text_out: got %h want %h", text_out, PT_C1); end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL c1_done_pulse: got %b want 0", done); end
        checks++; if (text_out !== PT_C1) begin errors++; $display("FAIL c1_text_hold: got %h want %h", text_out, PT_C1); end
    endtask

    task automatic test_back_to_back();
        int c, cnt0;
        cnt0 = done_cnt;
        load_key(KEY_B);
        wait_key(c);
        send_blk(CT_B);
        repeat (10) step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_early_done: got %b want 0", done); end
        send_blk(CT_E2);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done1: got %b want 1", done); end
        checks++; if (text_out !== PT_B) begin errors++; $display("FAIL b2b_text1: got %h want %h", text_out, PT_B); end
        wait_done(c);
        checks++; if (c != 11) begin errors++; $display("FAIL b2b_latency2: got %0d want 11", c); end
        checks++; if (text_out !== PT_E2) begin errors++; $display("FAIL b2b_text2: got %h want %h", text_out, PT_E2); end
        load_key(KEY_C1);
        wait_key(c);
        checks++; if (c != 10) begin errors++; $display("FAIL b2b_reload_latency: got %0d want 10", c); end
        send_blk(CT_C1);
        wait_done(c);
        checks++; if (text_out !== PT_C1) begin errors++; $display("FAIL b2b_text3: got %h want %h", text_out, PT_C1); end
        repeat (3) step();
        checks++; if (done_cnt - cnt0 != 3) begin errors++; $display("FAIL b2b_done_count: got %0d want 3", done_cnt - cnt0); end
    endtask

    task automatic test_round_trip();
        logic [127:0] k, pt, ct;
        int c;
        k  = 128'hcafebabedeadbeefdeadbeef00000000;
        pt = 128'h00ddfbfaa6ef99307afc4a0f6e42309d;
        ct = ref_encrypt_f(pt, k);
        load_key(k);
        wait_key(c);
        send_blk(ct);
        wait_done(c);
        checks++; if (c != 11) begin errors++; $display("FAIL rt_latency: got %0d want 11", c); end
        checks++; if (text_out !== pt) begin errors++; $display("FAIL rt_text_out: got %h want %h", text_out, pt); end
    endtask

    task automatic test_ignored_strobes();
        int c, cnt0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        cnt0 = done_cnt;
        send_blk(CT_C1);
        wait_done(c);
        checks++; if (c != 0) begin errors++; $display("FAIL ign_idle_ld: got done after %0d want none", c); end
        checks++; if (key_rdy !== 1'b0) begin errors++; $display("FAIL ign_idle_key_rdy: got %b want 0", key_rdy); end
        load_key(KEY_C1);
        repeat (3) step();
        send_blk(CT_B);
        wait_key(c);
        checks++; if (c != 6) begin errors++; $display("FAIL ign_kexp_ld: key_rdy after %0d want 6", c); end
        checks++; if (done_cnt != cnt0) begin errors++; $display("FAIL ign_kexp_done: got %0d want %0d", done_cnt, cnt0); end
        send_blk(CT_C1);
        repeat (2) step();
        send_blk(CT_B);
        step();
        load_key(KEY_B);
        step();
        kld = 1'b1; key = KEY_B; ld = 1'b1; text_in = CT_B;
        step();
        kld = 1'b0; ld = 1'b0;
        checks++; if (key_rdy !== 1'b1) begin errors++; $display("FAIL ign_dec_key_rdy: got %b want 1", key_rdy); end
        wait_done(c);
        checks++; if (c != 4) begin errors++; $display("FAIL ign_dec_latency: got %0d want 4", c); end
        checks++; if (text_out !== PT_C1) begin errors++; $display("FAIL ign_dec_text: got %h want %h", text_out, PT_C1); end
        repeat (15) step();
        checks++; if (done_cnt - cnt0 != 1) begin errors++; $display("FAIL ign_done_count: got %0d want 1", done_cnt - cnt0); end
        send_blk(CT_C1);
        wait_done(c);
        checks++; if (text_out !== PT_C1) begin errors++; $display("FAIL ign_key_kept: got %h want %h", text_out, PT_C1); end
    endtask

    task automatic test_reset_mid_op();
        int c;
        load_key(KEY_B);
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (key_rdy !== 1'b0) begin errors++; $display("FAIL rkexp_key_rdy: got %b want 0", key_rdy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rkexp_done: got %b want 0", done); end
        checks++; if (text_out !== 128'h0) begin errors++; $display("FAIL rkexp_text_out: got %h want 0", text_out); end
        repeat (12) step();
        checks++; if (key_rdy !== 1'b0) begin errors++; $display("FAIL rkexp_no_resume: got %b want 0", key_rdy); end
        send_blk(CT_B);
        wait_done(c);
        checks++; if (c != 0) begin errors++; $display("FAIL rkexp_ld_ignored: done after %0d want none", c); end
        load_key(KEY_C1);
        wait_key(c);
        send_blk(CT_C1);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (key_rdy !== 1'b0) begin errors++; $display("FAIL rdec_key_rdy: got %b want 0", key_rdy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rdec_done: got %b want 0", done); end
        wait_done(c);
        checks++; if (c != 0) begin errors++; $display("FAIL rdec_no_done: done after %0d want none", c); end
        send_blk(CT_C1);
        wait_done(c);
        checks++; if (c != 0) begin errors++; $display("FAIL rdec_ld_ignored: done after %0d want none", c); end
        checks++; if (text_out !== 128'h0) begin errors++; $display("FAIL rdec_text_out: got %h want 0", text_out); end
    endtask

    task automatic test_key_reload();
        int c;
        load_key(KEY_B);
        repeat (2) step();
        load_key(KEY_C1);
        repeat (9) step();
        checks++; if (key_rdy !== 1'b0) begin errors++; $display("FAIL reload_early: got %b want 0", key_rdy); end
        step();
        checks++; if (key_rdy !== 1'b1) begin errors++; $display("FAIL reload_key_rdy: got %b want 1", key_rdy); end
        send_blk(CT_C1);
        wait_done(c);
        checks++; if (c != 11) begin errors++; $display("FAIL reload_latency: got %0d want 11", c); end
        checks++; if (text_out !== PT_C1) begin errors++; $display("FAIL reload_text: got %h want %h", text_out, PT_C1); end
    endtask

    initial begin
        rst     = 1'b1;
        kld     = 1'b0;
        ld      = 1'b0;
        key     = '0;
        text_in = '0;
        test_reset();
        test_fips_c1();
        test_back_to_back();
        test_round_trip();
        test_ignored_strobes();
        test_reset_mid_op();
        test_key_reload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
